// File: rtl/servo_pkg.sv
// Shared types and constants for the servo slew limiter.
// Defaults match the ServoPWM bank (8 channels, 8-bit duty).
package servo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NUM_CH_DEF = 8;

  typedef enum logic {
    IDLE,
    UPDATE
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W_DEF = idx_w(NUM_CH_DEF);

endpackage

// File: rtl/tick_divider.sv
// Update-tick generator: free-running 0..TICK_DIV-1 counter
// that only advances while enabled.
module tick_divider #(
  parameter int TICK_DIV = 400000
) (
  input  logic clk,
  input  logic resetN,
  input  logic enable,
  output logic tickOut
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap  = (r_cnt == LAST);
  assign tickOut = w_wrap & enable;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/servo_slew_limiter.sv
// Rate-limits servo positions toward synchronised targets,
// sweeping one channel per clock after each update tick.
module servo_slew_limiter
  import servo_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TICK_DIV  = 400000,
  parameter int STEP      = 2,
  parameter int RESET_POS = 128
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic [NUM_CH*DATA_W-1:0] targetIn,
  input  logic                     enable,
  input  logic                     snap,
  output logic [NUM_CH*DATA_W-1:0] posOut,
  output logic [NUM_CH-1:0]        settled,
  output logic                     tickOut
);

  localparam int CH_W = idx_w(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [DATA_W:0] STEP_W = (DATA_W+1)'(STEP);
  localparam logic [DATA_W-1:0] RST_V = DATA_W'(RESET_POS);

  if (TICK_DIV < NUM_CH + 2) begin : g_bad_div
    $error("TICK_DIV must be >= NUM_CH+2");
  end
  if (STEP < 1 || STEP > (2**DATA_W) - 1) begin : g_bad_step
    $error("STEP out of range");
  end

  logic [DATA_W-1:0] r_s1  [NUM_CH];
  logic [DATA_W-1:0] r_s2  [NUM_CH];
  logic [DATA_W-1:0] r_tgt [NUM_CH];
  logic [DATA_W-1:0] r_pos [NUM_CH];
  logic [NUM_CH-1:0] r_settled;
  state_t            r_state;
  logic [CH_W-1:0]   r_idx;
  logic              r_snap_pend;

  logic              w_tick;
  logic [DATA_W-1:0] w_cur_pos;
  logic [DATA_W-1:0] w_cur_tgt;
  logic [DATA_W-1:0] w_slew;
  logic [DATA_W:0]   w_diff;
  logic              w_up;

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_div (
    .clk    (clk),
    .resetN (resetN),
    .enable (enable),
    .tickOut(w_tick)
  );

  assign tickOut = w_tick;
  assign settled = r_settled;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign posOut[g*DATA_W +: DATA_W] = r_pos[g];
  end

  // One datapath shared by all channels; extra bit keeps the
  // +/-STEP result from wrapping before it is clamped to tgt.
  always_comb begin
    w_cur_pos = r_pos[r_idx];
    w_cur_tgt = r_tgt[r_idx];
    w_up      = (w_cur_tgt > w_cur_pos);
    w_diff    = w_up ? ({1'b0, w_cur_tgt} - {1'b0, w_cur_pos})
                     : ({1'b0, w_cur_pos} - {1'b0, w_cur_tgt});
    w_slew    = w_cur_tgt;
    if (w_diff > STEP_W) begin
      if (w_up) begin
        w_slew = DATA_W'({1'b0, w_cur_pos} + STEP_W);
      end else begin
        w_slew = DATA_W'({1'b0, w_cur_pos} - STEP_W);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_s1[k]  <= RST_V;
        r_s2[k]  <= RST_V;
        r_tgt[k] <= RST_V;
        r_pos[k] <= RST_V;
      end
      r_settled   <= '0;
      r_state     <= IDLE;
      r_idx       <= '0;
      r_snap_pend <= 1'b0;
    end else begin
      // tgt only follows s2 once two samples agree: drops torn words
      for (int k = 0; k < NUM_CH; k++) begin
        r_s1[k] <= targetIn[k*DATA_W +: DATA_W];
        r_s2[k] <= r_s1[k];
        if (r_s1[k] == r_s2[k]) begin
          r_tgt[k] <= r_s2[k];
        end
        r_settled[k] <= (r_pos[k] == r_tgt[k]);
      end
      unique case (r_state)
        IDLE: begin
          if (snap || r_snap_pend) begin
            for (int k = 0; k < NUM_CH; k++) begin
              r_pos[k] <= r_tgt[k];
            end
            r_snap_pend <= 1'b0;
          end
          if (w_tick) begin
            r_state <= UPDATE;
            r_idx   <= '0;
          end
        end
        UPDATE: begin
          r_pos[r_idx] <= w_slew;
          if (snap) begin
            r_snap_pend <= 1'b1;
          end
          if (r_idx == LAST_CH) begin
            r_state <= IDLE;
          end else begin
            r_idx <= r_idx + CH_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
